// File: rtl/hcv_pkg.sv
// Shared definitions for the high-color video path: screen geometry,
// frame-buffer pixel-address packing and the fill engine state encoding.
package hcv_pkg;

   localparam int H_RES     = 1024;
   localparam int V_RES     = 768;
   localparam int X_BITS    = 10;
   localparam int Y_BITS    = 10;
   localparam int ADDR_BITS = X_BITS + Y_BITS;

   typedef enum logic [1:0] {
      FILL_IDLE,
      FILL_REQ,
      FILL_GAP,
      FILL_DONE
   } fill_state_e;

   function automatic logic [ADDR_BITS-1:0] pix_addr(input logic [Y_BITS-1:0] y,
                                                     input logic [X_BITS-1:0] x);
      return {y, x};
   endfunction

endpackage

// File: rtl/hcv_fill.sv
// Rectangle-fill engine: walks a clipped rectangle in raster order and issues
// one single-pixel write per pixel on the frame-buffer stb/ack port.
module hcv_fill #(
   parameter int H_RES = hcv_pkg::H_RES,
   parameter int V_RES = hcv_pkg::V_RES
) (
   input  logic                          pclk,
   input  logic                          rst,
   input  logic                          cmd_start,
   input  logic [hcv_pkg::X_BITS-1:0]    cmd_x,
   input  logic [hcv_pkg::Y_BITS-1:0]    cmd_y,
   input  logic [10:0]                   cmd_w,
   input  logic [9:0]                    cmd_h,
   input  logic [15:0]                   cmd_color,
   output logic                          busy,
   output logic                          done,
   output logic                          fb_stb,
   output logic                          fb_we,
   output logic [hcv_pkg::ADDR_BITS-1:0] fb_addr,
   output logic [15:0]                   fb_data,
   input  logic                          fb_ack
);
   import hcv_pkg::*;

   fill_state_e       state, state_d;
   logic [X_BITS-1:0] cx, cx_d, x0, x0_d, xe, xe_d;
   logic [Y_BITS-1:0] cy, cy_d, ye, ye_d;
   logic [15:0]       color, color_d;
   logic [11:0]       x_sum, y_sum, x_lim, y_lim;
   logic              empty, last_px;

   // Clip the requested extents against the visible area; sums are widened so
   // a large width cannot wrap back on screen.
   always_comb begin
      x_sum = {2'b00, cmd_x} + {1'b0, cmd_w};
      y_sum = {2'b00, cmd_y} + {2'b00, cmd_h};
      x_lim = (x_sum > 12'(H_RES)) ? 12'(H_RES) : x_sum;
      y_lim = (y_sum > 12'(V_RES)) ? 12'(V_RES) : y_sum;
      empty = (cmd_w == '0) || (cmd_h == '0) ||
              ({2'b00, cmd_x} >= 12'(H_RES)) || ({2'b00, cmd_y} >= 12'(V_RES));
   end

   assign last_px = (cx == xe) && (cy == ye);

   always_comb begin
      state_d = state;
      cx_d    = cx;
      cy_d    = cy;
      x0_d    = x0;
      xe_d    = xe;
      ye_d    = ye;
      color_d = color;
      case (state)
         FILL_IDLE, FILL_DONE: begin
            state_d = FILL_IDLE;
            if (cmd_start) begin
               x0_d    = cmd_x;
               cx_d    = cmd_x;
               cy_d    = cmd_y;
               xe_d    = X_BITS'(x_lim - 12'd1);
               ye_d    = Y_BITS'(y_lim - 12'd1);
               color_d = cmd_color;
               state_d = empty ? FILL_DONE : FILL_REQ;
            end
         end
         FILL_REQ: begin
            if (fb_ack) begin
               if (last_px) begin
                  state_d = FILL_DONE;
               end else begin
                  state_d = FILL_GAP;
                  if (cx < xe) begin
                     cx_d = cx + 1'b1;
                  end else begin
                     cx_d = x0;
                     cy_d = cy + 1'b1;
                  end
               end
            end
         end
         // The controller keeps ack high one cycle past the transfer; this idle
         // cycle swallows it so it is not taken as the next pixel's ack.
         FILL_GAP: state_d = FILL_REQ;
         default:  state_d = FILL_IDLE;
      endcase
   end

   always_ff @(posedge pclk) begin
      if (rst) begin
         state   <= FILL_IDLE;
         busy    <= 1'b0;
         done    <= 1'b0;
         fb_stb  <= 1'b0;
         fb_we   <= 1'b0;
         fb_addr <= '0;
         fb_data <= '0;
      end else begin
         state  <= state_d;
         busy   <= (state_d == FILL_REQ) || (state_d == FILL_GAP);
         done   <= (state_d == FILL_DONE);
         fb_stb <= (state_d == FILL_REQ);
         fb_we  <= (state_d == FILL_REQ);
         if (state_d == FILL_REQ) begin
            fb_addr <= pix_addr(cy_d, cx_d);
            fb_data <= color_d;
         end
      end
   end

   always_ff @(posedge pclk) begin
      cx    <= cx_d;
      cy    <= cy_d;
      x0    <= x0_d;
      xe    <= xe_d;
      ye    <= ye_d;
      color <= color_d;
   end

endmodule
